conv_mac_acc: RTL and testbench



---
 rtl/conv_mac_acc_if.sv | 21 ++
 rtl/conv_mac_acc.sv | 70 +++++++
 tb/tb_conv_mac_acc.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/conv_mac_acc_if.sv
// Bus bundle for one conv_mac_acc lane: operands and control in, accumulator and overflow flag out.
interface conv_mac_acc_if #(
  parameter int WIDTH = 16
);
  logic                 clr;
  logic                 layer_en;
  logic [WIDTH-1:0]     pix;
  logic [WIDTH-1:0]     ker;
  logic [2*WIDTH-1:0]   mul_out;
  logic                 ovf;

  modport master (
    output clr, layer_en, pix, ker,
    input  mul_out, ovf
  );

  modport slave (
    input  clr, layer_en, pix, ker,
    output mul_out, ovf
  );
endinterface

// File: rtl/conv_mac_acc.sv
// Signed multiply-accumulate lane with sticky per-window overflow flag and synchronous window clear.
// Optional MAC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module conv_mac_acc #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  conv_mac_acc_if.slave   bus
);

  localparam int AW = 2 * WIDTH;

  logic [AW-1:0] r_acc;
  logic          r_ovf;

  logic [AW-1:0] w_pix_ext;
  logic [AW-1:0] w_ker_ext;
  logic [AW-1:0] w_prod;
  logic [AW:0]   w_sum;
  logic          w_ovf;
  logic [AW-1:0] w_acc_nxt;

  // Product and one-bit-wider sum; overflow is a disagreement between the true and truncated sign.
  always_comb begin
    w_pix_ext = {{WIDTH{bus.pix[WIDTH-1]}}, bus.pix};
    w_ker_ext = {{WIDTH{bus.ker[WIDTH-1]}}, bus.ker};
    w_prod    = w_pix_ext * w_ker_ext;
    w_sum     = {r_acc[AW-1], r_acc} + {w_prod[AW-1], w_prod};
    w_ovf     = w_sum[AW] ^ w_sum[AW-1];
  end

  // Next accumulator value: clamp toward the true sign on overflow, or wrap.
  always_comb begin
    w_acc_nxt = w_sum[AW-1:0];
`ifdef MAC_SAT_EN
    if (w_ovf) begin
      if (w_sum[AW]) begin
        w_acc_nxt = {1'b1, {(AW-1){1'b0}}};
      end else begin
        w_acc_nxt = {1'b0, {(AW-1){1'b1}}};
      end
    end else begin
      w_acc_nxt = w_sum[AW-1:0];
    end
`else
    w_acc_nxt = w_sum[AW-1:0];
`endif
  end

  // Accumulator and sticky overflow; clr wins over layer_en and discards the current product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= {AW{1'b0}};
      r_ovf <= 1'b0;
    end else if (bus.clr) begin
      r_acc <= {AW{1'b0}};
      r_ovf <= 1'b0;
    end else if (bus.layer_en) begin
      r_acc <= w_acc_nxt;
      r_ovf <= r_ovf | w_ovf;
    end else begin
      r_acc <= r_acc;
      r_ovf <= r_ovf;
    end
  end

  assign bus.mul_out = r_acc;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_conv_mac_acc.sv
// Directed bench for conv_mac_acc: vector table plus window, async-reset and gating sequences.
module tb_conv_mac_acc;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  conv_mac_acc_if #(.WIDTH(W)) bus ();

  conv_mac_acc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic        en;
    logic [15:0] pix;
    logic [15:0] ker;
    logic [31:0] exp_mul;
    logic        exp_ovf;
    string       name;
  } vec_t;

  vec_t vecs[$];

`ifdef MAC_SAT_EN
  localparam logic [31:0] POS_OVF_EXP = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OVF_EXP = 32'h8000_0000;
  localparam logic [31:0] NEG_RECOV   = 32'h8000_0001;
`else
  localparam logic [31:0] POS_OVF_EXP = 32'h8000_0000;
  localparam logic [31:0] NEG_OVF_EXP = 32'h4001_8000;
  localparam logic [31:0] NEG_RECOV   = 32'h4001_8001;
`endif

  task automatic add(input logic r, input logic c, input logic e, input logic [15:0] p,
                     input logic [15:0] k, input logic [31:0] m, input logic o, input string n);
    vec_t v;
    v.rst_n = r; v.clr = c; v.en = e; v.pix = p; v.ker = k;
    v.exp_mul = m; v.exp_ovf = o; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act_m, input logic act_o,
                       input logic [31:0] exp_m, input logic exp_o);
    checks++;
    if (act_m !== exp_m || act_o !== exp_o) begin
      errors++;
      $display("FAIL %s: got mul_out=%h ovf=%b, expected mul_out=%h ovf=%b",
               n, act_m, act_o, exp_m, exp_o);
    end
  endtask

  task automatic drive(input logic c, input logic e, input logic [15:0] p, input logic [15:0] k);
    bus.clr = c; bus.layer_en = e; bus.pix = p; bus.ker = k;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'd0, 16'd0);

    // rst clr en pix ker -> mul_out ovf after the edge
    add(0, 0, 1, 16'd5, 16'd7, 32'd0, 0, "reset_hold0");
    add(0, 0, 1, 16'd5, 16'd7, 32'd0, 0, "reset_hold1");
    add(0, 0, 1, 16'd5, 16'd7, 32'd0, 0, "reset_hold2");
    add(1, 0, 1, 16'd5, 16'd7, 32'd35, 0, "acc35");
    add(1, 0, 1, 16'd5, 16'd7, 32'd70, 0, "acc70");
    add(1, 0, 1, 16'd5, 16'd7, 32'd105, 0, "acc105");
    add(1, 1, 0, 16'd5, 16'd7, 32'd0, 0, "clr1");
    add(1, 0, 1, 16'hFFFD, 16'd4, 32'hFFFF_FFF4, 0, "neg_times_pos");
    add(1, 0, 1, 16'hFFFE, 16'hFFFB, 32'hFFFF_FFFE, 0, "neg_times_neg");
    add(1, 1, 0, 16'd0, 16'd0, 32'd0, 0, "clr2");
    add(1, 0, 1, 16'h8000, 16'h8000, 32'h4000_0000, 0, "min_sq");
    add(1, 1, 0, 16'd0, 16'd0, 32'd0, 0, "clr3");
    add(1, 0, 1, 16'd10, 16'd10, 32'd100, 0, "gate_acc1");
    add(1, 0, 1, 16'd10, 16'd10, 32'd200, 0, "gate_acc2");
    add(1, 0, 0, 16'h1234, 16'h7FFF, 32'd200, 0, "gate_hold0");
    add(1, 0, 0, 16'h8000, 16'hFFFF, 32'd200, 0, "gate_hold1");
    add(1, 0, 0, 16'hABCD, 16'h0042, 32'd200, 0, "gate_hold2");
    add(1, 0, 0, 16'hxxxx, 16'hxxxx, 32'd200, 0, "gate_hold_x");
    add(1, 0, 0, 16'h0001, 16'h0001, 32'd200, 0, "gate_hold4");
    add(1, 0, 1, 16'd10, 16'd10, 32'd300, 0, "gate_resume");
    add(1, 1, 0, 16'd0, 16'd0, 32'd0, 0, "clr4");
    add(1, 0, 1, 16'h8000, 16'h8000, 32'h4000_0000, 0, "povf_step1");
    add(1, 0, 1, 16'h8000, 16'h8000, POS_OVF_EXP, 1, "povf_step2");
    add(1, 0, 0, 16'h0000, 16'h0000, POS_OVF_EXP, 1, "povf_sticky");
    add(1, 1, 1, 16'h8000, 16'h8000, 32'd0, 0, "povf_clr");
    add(1, 1, 1, 16'd9, 16'd9, 32'd0, 0, "clr_priority");
    add(1, 1, 0, 16'd9, 16'd9, 32'd0, 0, "clr_b2b");
    add(1, 0, 1, 16'h8000, 16'h7FFF, 32'hC000_8000, 0, "novf_step1");
    add(1, 0, 1, 16'h8000, 16'h7FFF, 32'h8001_0000, 0, "novf_step2");
    add(1, 0, 1, 16'h8000, 16'h7FFF, NEG_OVF_EXP, 1, "novf_step3");
    add(1, 0, 1, 16'd1, 16'd1, NEG_RECOV, 1, "novf_recover");
    add(1, 1, 0, 16'd0, 16'd0, 32'd0, 0, "clr5");

    #2;
    check("reset_async_init", bus.mul_out, bus.ovf, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst_n;
      drive(vecs[i].clr, vecs[i].en, vecs[i].pix, vecs[i].ker);
      @(posedge clk);
      #1;
      check(vecs[i].name, bus.mul_out, bus.ovf, vecs[i].exp_mul, vecs[i].exp_ovf);
    end

    // Full 144-product window followed by its clr cycle.
    for (int i = 1; i <= 144; i++) begin
      drive(1'b0, 1'b1, 16'(i), 16'd2);
      @(posedge clk);
      #1;
    end
    drive(1'b1, 1'b1, 16'd7, 16'd7);
    #1;
    check("window_sum_in_clr_cycle", bus.mul_out, bus.ovf, 32'd20880, 1'b0);
    @(posedge clk);
    #1;
    check("window_cleared", bus.mul_out, bus.ovf, 32'd0, 1'b0);
    drive(1'b0, 1'b1, 16'd3, 16'd3);
    @(posedge clk);
    #1;
    check("window_fresh", bus.mul_out, bus.ovf, 32'd9, 1'b0);

    // Random operands while gated off must not disturb the partial sum.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      @(posedge clk);
      #1;
    end
    check("gate_random_hold", bus.mul_out, bus.ovf, 32'd9, 1'b0);

    // Asynchronous reset between clock edges.
    drive(1'b0, 1'b1, 16'd3, 16'd3);
    @(posedge clk);
    #1;
    check("pre_async_reset", bus.mul_out, bus.ovf, 32'd18, 1'b0);
    rst = 1'b0;
    #1;
    check("async_reset_no_edge", bus.mul_out, bus.ovf, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b1, 16'd4, 16'd5);
    @(posedge clk);
    #1;
    check("after_async_reset", bus.mul_out, bus.ovf, 32'd20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
